imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Boot-time writer for the instruction memory read by the fetch stage.
//   Accepts a byte stream over a valid/ready handshake and packs it into big-endian words.
//   Writes each word to consecutive word addresses and holds the core in reset until the image is complete.
//   Sits between the host link (UART/debug byte source) and the write port of the instruction RAM.
// PARAMETERS
//   ADDR_SIZE  10            word-address width of instruction memory (depth 2**ADDR_SIZE)
//   WORD_SIZE  32            instruction width; fixed at 32 (4 bytes/word), other values unsupported
//   BOOT_ADDR  32'h00000000  first word address written; low ADDR_SIZE bits used
// PORTS
//   clk_i       in   1          single clock
//   rst_n_i     in   1          asynchronous active-low reset
//   rx_data_i   in   8          stream byte
//   rx_valid_i  in   1          rx_data_i valid
//   rx_ready_o  out  1          loader accepts byte this cycle
//   reload_i    in   1          in DONE: restart load sequence (single-cycle pulse)
//   we_o        out  1          imem write strobe (one cycle per word)
//   waddr_o     out  ADDR_SIZE  imem word address
//   wdata_o     out  WORD_SIZE  imem write data
//   cpu_rst_o   out  1          active-high reset to core/fetch; high until load complete
//   done_o      out  1          image loaded, core released
//   err_o       out  1          load failed; sticky until reset
// BEHAVIOUR
//   Reset (async): state=HDR_HI, rx_ready_o=0 for one cycle then per state, we_o=0, waddr_o=BOOT_ADDR,
//     wdata_o=0, cpu_rst_o=1, done_o=0, err_o=0; partial word discarded, RAM contents untouched.
//   Byte accepted iff rx_valid_i && rx_ready_o on a rising edge; rx_ready_o=1 in HDR_HI/HDR_LO/DATA/CSUM only.
//   Frame: count N (16b, MSB first), then 4*N data bytes, MSB of each word first.
//   States: HDR_HI -> HDR_LO -> DATA -> (CSUM) -> DONE; any -> ERR on fault.
//     HDR_LO: N==0 -> DONE (or CSUM); N > 2**ADDR_SIZE -> ERR; else -> DATA.
//     DATA: 4th byte of word accepted at edge t -> we_o=1 for the cycle after t, with wdata_o/waddr_o valid.
//       waddr increments after each write, wrapping modulo 2**ADDR_SIZE (only possible when BOOT_ADDR!=0).
//     After word N is accepted: -> DONE (or CSUM); the final we_o pulse and state change share the same edge.
//     DONE: done_o=1, cpu_rst_o=0, no bytes accepted; reload_i -> HDR_HI, cpu_rst_o=1, done_o=0,
//       waddr_o=BOOT_ADDR, all in the next cycle.
//     ERR: err_o=1, cpu_rst_o=1, rx_ready_o=0; exit only via rst_n_i; reload_i ignored.
//   Word counter 16b; byte-in-word counter 2b; rx_valid_i gaps stall without loss.
//   reload_i outside DONE ignored.
// CONFIGURATION
//   IMEM_LOADER_CSUM_EN defined: one trailing byte follows the data (CSUM state).
//     Checksum = 8-bit mod-256 sum of all data bytes (header excluded).
//     Match -> DONE; mismatch -> ERR. cpu_rst_o stays 1 until the checksum passes.
//     Words are still written to RAM as they arrive.
//   Undefined: no CSUM state; DONE directly after the last word; err_o only from an oversize N.
// STRUCTURE
//   Package mips_pkg: loader state encoding, BYTES_PER_WORD=4, HDR_BYTES=2.
//   Sub-module word_packer: byte shift register plus 2b counter.
//     Outputs word_valid pulse and word; cleared by a sync clear from the FSM on reload.
//   FSM, counters, address register and checksum accumulator stay in imem_loader.
// TESTING
//   1) N=2, bytes 00 02 | 24 08 00 05 | 08 00 00 00
//      -> we_o twice: addr0=32'h24080005, addr1=32'h08000000; done_o=1, cpu_rst_o=0 after.
//   2) N=0 (00 00) -> no we_o, done_o=1 the cycle after the 2nd byte.
//      With CSUM_EN: a trailing 00 is required first.
//   3) N=16'h0401, ADDR_SIZE=10 -> err_o=1 after 2nd header byte; rx_ready_o=0; cpu_rst_o=1 held.
//   4) rx_valid_i toggled randomly mid-word, with rst_n_i pulsed low mid-frame
//      -> outputs return to reset values immediately; a fresh frame loads correctly from BOOT_ADDR.
//   5) After DONE pulse reload_i, resend image with different data
//      -> cpu_rst_o=1 next cycle, RAM overwritten, done_o reasserts.
//   6) CSUM_EN: N=1, data 01 02 03 04, checksum 0A -> done_o.
//      Same frame with checksum 0B -> err_o=1, cpu_rst_o stays 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding and framing constants.
package mips_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned HDR_BYTES      = 2;
   localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      ST_HDR_HI = 3'd0,
      ST_HDR_LO = 3'd1,
      ST_DATA   = 3'd2,
      ST_CSUM   = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR    = 3'd5
   } ld_state_e;

   // States in which the loader takes bytes from the host link
   function automatic logic accepts_bytes(input ld_state_e s);
      return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream into big-endian 32-bit words; word_valid_c/word_c are combinational
// and valid in the cycle the fourth byte of a word is presented.
module word_packer
   import mips_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        clr_i,
   input  logic [7:0]  byte_i,
   input  logic        byte_valid_i,
   output logic        word_valid_c,
   output logic [31:0] word_c
);

   logic [23:0]           shreg_q;
   logic [BYTE_CNT_W-1:0] cnt_q;

   // Earlier bytes shift toward the MSB so the first byte ends up in bits 31:24
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else if (clr_i) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else if (byte_valid_i) begin
         shreg_q <= {shreg_q[15:0], byte_i};
         cnt_q   <= cnt_q + BYTE_CNT_W'(1);
      end
   end

   assign word_valid_c = byte_valid_i && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
   assign word_c       = {shreg_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: byte stream -> word writes, core held in reset until loaded.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_SIZE = 10,
   parameter int unsigned WORD_SIZE = 32,
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [7:0]           rx_data_i,
   input  logic                 rx_valid_i,
   output logic                 rx_ready_o,
   input  logic                 reload_i,
   output logic                 we_o,
   output logic [ADDR_SIZE-1:0] waddr_o,
   output logic [WORD_SIZE-1:0] wdata_o,
   output logic                 cpu_rst_o,
   output logic                 done_o,
   output logic                 err_o
);

   localparam logic [ADDR_SIZE-1:0] BOOT_WADDR = ADDR_SIZE'(BOOT_ADDR);
   localparam logic [32:0]          DEPTH      = 33'(1) << ADDR_SIZE;
`ifdef IMEM_LOADER_CSUM_EN
   localparam ld_state_e END_ST = ST_CSUM;
`else
   localparam ld_state_e END_ST = ST_DONE;
`endif

   ld_state_e   state_q, state_d;
   logic [15:0] n_q;
   logic [15:0] word_cnt_q;
   logic        accept_c;
   logic        reload_c;
   logic        last_word_c;
   logic        pk_valid_c;
   logic [31:0] pk_word_c;
   logic [15:0] hdr_n_c;

   assign accept_c    = rx_valid_i && rx_ready_o;
   assign reload_c    = reload_i && (state_q == ST_DONE);
   assign hdr_n_c     = {n_q[15:8], rx_data_i};
   assign last_word_c = pk_valid_c && ((17'(word_cnt_q) + 17'd1) == 17'(n_q));

`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0] csum_q;

   // Mod-256 sum of data bytes only; the header is not covered
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         csum_q <= '0;
      end else if (reload_c) begin
         csum_q <= '0;
      end else if (accept_c && (state_q == ST_DATA)) begin
         csum_q <= csum_q + rx_data_i;
      end
   end
`endif

   word_packer u_packer (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .clr_i        (reload_c),
      .byte_i       (rx_data_i),
      .byte_valid_i (accept_c && (state_q == ST_DATA)),
      .word_valid_c (pk_valid_c),
      .word_c       (pk_word_c)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_HDR_HI;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_HDR_HI: if (accept_c) state_d = ST_HDR_LO;
         ST_HDR_LO: begin
            if (accept_c) begin
               if (hdr_n_c == 16'd0) begin
                  state_d = END_ST;
               end else if (33'(hdr_n_c) > DEPTH) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA:   if (last_word_c) state_d = END_ST;
`ifdef IMEM_LOADER_CSUM_EN
         ST_CSUM: begin
            if (accept_c) state_d = (rx_data_i == csum_q) ? ST_DONE : ST_ERR;
         end
`endif
         ST_DONE:   if (reload_i) state_d = ST_HDR_HI;
         ST_ERR:    state_d = ST_ERR;
         default:   state_d = ST_ERR;
      endcase
   end

   // Status outputs registered from the next state so they change together with it
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rx_ready_o <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         cpu_rst_o  <= 1'b1;
      end else begin
         rx_ready_o <= accepts_bytes(state_d);
         done_o     <= (state_d == ST_DONE);
         err_o      <= (state_d == ST_ERR);
         cpu_rst_o  <= (state_d != ST_DONE);
      end
   end

   // Write port: address advances after each strobe and wraps naturally at the RAM depth
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         we_o    <= 1'b0;
         wdata_o <= '0;
         waddr_o <= BOOT_WADDR;
      end else begin
         we_o <= pk_valid_c;
         if (pk_valid_c) begin
            wdata_o <= WORD_SIZE'(pk_word_c);
         end
         if (reload_c) begin
            waddr_o <= BOOT_WADDR;
         end else if (we_o) begin
            waddr_o <= waddr_o + ADDR_SIZE'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         n_q        <= '0;
         word_cnt_q <= '0;
      end else begin
         if (accept_c && (state_q == ST_HDR_HI)) n_q[15:8] <= rx_data_i;
         if (accept_c && (state_q == ST_HDR_LO)) n_q[7:0]  <= rx_data_i;
         if (reload_c) begin
            word_cnt_q <= '0;
         end else if (pk_valid_c) begin
            word_cnt_q <= word_cnt_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a frame-level reference model (IMEM_LOADER_CSUM_EN aware).
module tb_imem_loader;

   localparam int unsigned ADDR_SIZE = 10;
   localparam int unsigned WORD_SIZE = 32;
   localparam logic [31:0] BOOT_ADDR = 32'h0000_0000;
   localparam int unsigned DEPTH     = 1 << ADDR_SIZE;

   logic                 clk_i = 1'b0;
   logic                 rst_n_i = 1'b1;
   logic [7:0]           rx_data_i = '0;
   logic                 rx_valid_i = 1'b0;
   logic                 rx_ready_o;
   logic                 reload_i = 1'b0;
   logic                 we_o;
   logic [ADDR_SIZE-1:0] waddr_o;
   logic [WORD_SIZE-1:0] wdata_o;
   logic                 cpu_rst_o;
   logic                 done_o;
   logic                 err_o;

   int checks = 0;
   int failures = 0;

   logic [ADDR_SIZE-1:0] obs_addr[$];
   logic [WORD_SIZE-1:0] obs_data[$];

   imem_loader #(
      .ADDR_SIZE (ADDR_SIZE),
      .WORD_SIZE (WORD_SIZE),
      .BOOT_ADDR (BOOT_ADDR)
   ) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .rx_data_i  (rx_data_i),
      .rx_valid_i (rx_valid_i),
      .rx_ready_o (rx_ready_o),
      .reload_i   (reload_i),
      .we_o       (we_o),
      .waddr_o    (waddr_o),
      .wdata_o    (wdata_o),
      .cpu_rst_o  (cpu_rst_o),
      .done_o     (done_o),
      .err_o      (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Capture RAM writes away from the active edge
   always @(negedge clk_i) begin
      if (we_o === 1'b1) begin
         obs_addr.push_back(waddr_o);
         obs_data.push_back(wdata_o);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one byte with random valid gaps and stray reload pulses; returns once it will be taken
   task automatic send_byte(input logic [7:0] b, output bit ok);
      ok = 1'b0;
      for (int budget = 0; budget < 200; budget++) begin
         @(negedge clk_i);
         reload_i = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) begin
            rx_valid_i = 1'b0;
            rx_data_i  = 8'($urandom);
         end else begin
            rx_valid_i = 1'b1;
            rx_data_i  = b;
            if (rx_ready_o) begin
               ok = 1'b1;
               break;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         rx_valid_i = 1'b0;
         reload_i   = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rx_valid_i = 1'b0;
      reload_i   = 1'b0;
      #2 rst_n_i = 1'b0;
      #1;
      check("rst_we", 64'(we_o), 64'd0);
      check("rst_waddr", 64'(waddr_o), 64'(ADDR_SIZE'(BOOT_ADDR)));
      check("rst_wdata", 64'(wdata_o), 64'd0);
      check("rst_cpu_rst", 64'(cpu_rst_o), 64'd1);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_err", 64'(err_o), 64'd0);
      check("rst_ready", 64'(rx_ready_o), 64'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      #1 check("rst_ready_first", 64'(rx_ready_o), 64'd0);
      @(negedge clk_i);
      check("rst_ready_after", 64'(rx_ready_o), 64'd1);
   endtask

   task automatic do_reload();
      @(negedge clk_i);
      rx_valid_i = 1'b0;
      reload_i   = 1'b1;
      @(negedge clk_i);
      reload_i = 1'b0;
      check("reload_cpu_rst", 64'(cpu_rst_o), 64'd1);
      check("reload_done", 64'(done_o), 64'd0);
      check("reload_waddr", 64'(waddr_o), 64'(ADDR_SIZE'(BOOT_ADDR)));
      check("reload_ready", 64'(rx_ready_o), 64'd1);
   endtask

   task automatic make_words(input int n, output logic [31:0] q[$]);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back($urandom);
   endtask

   // Reference: frame = N (MSB first), words MSB first, optional mod-256 data checksum;
   // word i lands at (BOOT + i) mod DEPTH; N above DEPTH is an error with no writes.
   task automatic run_frame(input logic [31:0] words[$], input logic [15:0] n, input bit bad_csum);
      logic [7:0] bytes[$];
      logic [7:0] sum;
      logic [31:0] w;
      bit oversize, exp_err, exp_done, all_ok, ok;
      int exp_writes;
      sum      = 8'h00;
      oversize = (32'(n) > 32'(DEPTH));
      bytes.push_back(n[15:8]);
      bytes.push_back(n[7:0]);
      if (!oversize) begin
         for (int i = 0; i < int'(n); i++) begin
            w = words[i];
            for (int k = 3; k >= 0; k--) begin
               bytes.push_back(w[k*8 +: 8]);
               sum = sum + w[k*8 +: 8];
            end
         end
`ifdef IMEM_LOADER_CSUM_EN
         bytes.push_back(bad_csum ? 8'(sum + 8'd1) : sum);
`endif
      end
      exp_err    = oversize || bad_csum;
      exp_done   = !exp_err;
      exp_writes = oversize ? 0 : int'(n);
      obs_addr.delete();
      obs_data.delete();
      all_ok = 1'b1;
      foreach (bytes[i]) begin
         send_byte(bytes[i], ok);
         all_ok = all_ok && ok;
      end
      @(negedge clk_i);
      rx_valid_i = 1'b0;
      reload_i   = 1'b0;
      check("frame_accept", 64'(all_ok), 64'd1);
      check("end_done", 64'(done_o), 64'(exp_done));
      check("end_err", 64'(err_o), 64'(exp_err));
      check("end_cpu_rst", 64'(cpu_rst_o), 64'(!exp_done));
      check("end_ready", 64'(rx_ready_o), 64'd0);
      idle(2);
      check("write_count", 64'(obs_addr.size()), 64'(exp_writes));
      for (int i = 0; i < exp_writes && i < obs_addr.size(); i++) begin
         check("write_addr", 64'(obs_addr[i]), 64'(ADDR_SIZE'(BOOT_ADDR + 32'(i))));
         check("write_data", 64'(obs_data[i]), 64'(words[i]));
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] wq[$];
      bit ok;

      do_reset();

      // Fixed two-word image
      wq.delete();
      wq.push_back(32'h2408_0005);
      wq.push_back(32'h0800_0000);
      run_frame(wq, 16'd2, 1'b0);

      // Reload and overwrite with different data
      do_reload();
      make_words(5, wq);
      run_frame(wq, 16'd5, 1'b0);

      // Empty image
      do_reload();
      wq.delete();
      run_frame(wq, 16'd0, 1'b0);

      for (int r = 0; r < 3; r++) begin
         int n;
         n = $urandom_range(1, 9);
         do_reload();
         make_words(n, wq);
         run_frame(wq, 16'(n), 1'b0);
      end

      // Reset in the middle of a word, then a fresh load from the boot address
      do_reload();
      send_byte(8'h00, ok);
      send_byte(8'h03, ok);
      for (int i = 0; i < 6; i++) send_byte(8'($urandom), ok);
      @(posedge clk_i);
      #2 rst_n_i = 1'b0;
      rx_valid_i = 1'b0;
      reload_i   = 1'b0;
      #1;
      check("midrst_we", 64'(we_o), 64'd0);
      check("midrst_waddr", 64'(waddr_o), 64'(ADDR_SIZE'(BOOT_ADDR)));
      check("midrst_cpu_rst", 64'(cpu_rst_o), 64'd1);
      check("midrst_ready", 64'(rx_ready_o), 64'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      idle(1);
      make_words(3, wq);
      run_frame(wq, 16'd3, 1'b0);

      // Largest legal image fills the whole RAM
      do_reload();
      make_words(DEPTH, wq);
      run_frame(wq, 16'(DEPTH), 1'b0);

      // One word too many is rejected; reload cannot leave the error state
      do_reset();
      wq.delete();
      run_frame(wq, 16'h0401, 1'b0);
      @(negedge clk_i);
      reload_i = 1'b1;
      @(negedge clk_i);
      reload_i = 1'b0;
      idle(1);
      check("err_sticky", 64'(err_o), 64'd1);
      check("err_cpu_rst", 64'(cpu_rst_o), 64'd1);
      check("err_done", 64'(done_o), 64'd0);
      check("err_ready", 64'(rx_ready_o), 64'd0);

`ifdef IMEM_LOADER_CSUM_EN
      do_reset();
      wq.delete();
      wq.push_back(32'h0102_0304);
      run_frame(wq, 16'd1, 1'b0);
      do_reload();
      run_frame(wq, 16'd1, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
